// File: rtl/mips_cpu_bus_pkg.sv
// Shared definitions for the bus CPU decode path: extension mode codes and
// default operand geometry.
package mips_cpu_bus_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_IMM_WIDTH  = 16;
    localparam int DEFAULT_SA_WIDTH   = 5;
    localparam int DEFAULT_TAG_WIDTH  = 5;

    // Codes 5..7 are unassigned and extend to zero.
    typedef enum logic [2:0] {
        EXT_SIGN   = 3'd0,
        EXT_ZERO   = 3'd1,
        EXT_LUI    = 3'd2,
        EXT_SHAMT  = 3'd3,
        EXT_BRANCH = 3'd4
    } ext_mode_t;

endpackage

// File: rtl/mips_cpu_bus_extend_stage_if.sv
// Handshake bundle for the operand-extension stage: input offer side and
// registered output side. The slave modport is the stage's view.
interface mips_cpu_bus_extend_stage_if
    import mips_cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMM_WIDTH  = DEFAULT_IMM_WIDTH,
    parameter int SA_WIDTH   = DEFAULT_SA_WIDTH,
    parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IMM_WIDTH-1:0]  in_imm;
    logic [SA_WIDTH-1:0]   in_sa;
    logic [2:0]            in_mode;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output in_valid, in_imm, in_sa, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_sa, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/mips_cpu_bus_extend_unit.sv
// Combinational mode -> operand function. Turns an immediate or shift amount
// into a full-width operand; unassigned mode codes give zero.
module mips_cpu_bus_extend_unit
    import mips_cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMM_WIDTH  = DEFAULT_IMM_WIDTH,
    parameter int SA_WIDTH   = DEFAULT_SA_WIDTH
) (
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic [SA_WIDTH-1:0]   sa,
    input  logic [2:0]            mode,
    output logic [DATA_WIDTH-1:0] operand
);
    localparam int UPPER = DATA_WIDTH - IMM_WIDTH;

    logic [DATA_WIDTH-1:0] imm_sext;

    assign imm_sext = {{UPPER{imm[IMM_WIDTH-1]}}, imm};

    // Select the extension; the branch shift drops the two top bits.
    always_comb begin
        operand = '0;
        case (mode)
            EXT_SIGN:   operand = imm_sext;
            EXT_ZERO:   operand = {{UPPER{1'b0}}, imm};
            EXT_LUI:    operand = {imm, {UPPER{1'b0}}};
            EXT_SHAMT:  operand = {{(DATA_WIDTH-SA_WIDTH){1'b0}}, sa};
            EXT_BRANCH: operand = imm_sext << 2;
            default:    operand = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_bus_extend_stage.sv
// Registered operand-extension stage with a two-entry skid buffer.
//
//   state | meaning
//   EMPTY | no entry held, out_valid low
//   ONE   | main register holds the oldest entry
//   FULL  | main and skid both hold entries; upstream is stalled
//
// in_ready is a register that mirrors "skid empty", so there is no path from
// out_ready to in_ready and no path from in_* to out_*.
module mips_cpu_bus_extend_stage
    import mips_cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMM_WIDTH  = DEFAULT_IMM_WIDTH,
    parameter int SA_WIDTH   = DEFAULT_SA_WIDTH,
    parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH
) (
    input logic clk,
    input logic reset,
    input logic flush,
    mips_cpu_bus_extend_stage_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic                  out_valid_q;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] main_data;
    logic [TAG_WIDTH-1:0]  main_tag;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [TAG_WIDTH-1:0]  skid_tag;
    logic [DATA_WIDTH-1:0] ext_operand;
    logic                  accept;
    logic                  drain;

    mips_cpu_bus_extend_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH),
        .SA_WIDTH   (SA_WIDTH)
    ) u_extend (
        .imm     (bus.in_imm),
        .sa      (bus.in_sa),
        .mode    (bus.in_mode),
        .operand (ext_operand)
    );

    assign accept = bus.in_valid && in_ready_q && !flush;
    assign drain  = out_valid_q && bus.out_ready;

    // Buffer state, storage and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_data   <= '0;
            main_tag    <= '0;
            skid_data   <= '0;
            skid_tag    <= '0;
        end else if (flush) begin
            // A drain in this cycle has already been taken by downstream.
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data   <= ext_operand;
                        main_tag    <= bus.in_tag;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_data <= ext_operand;
                        main_tag  <= bus.in_tag;
                    end else if (accept) begin
                        skid_data  <= ext_operand;
                        skid_tag   <= bus.in_tag;
                        in_ready_q <= 1'b0;
                        state      <= FULL;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_data  <= skid_data;
                        main_tag   <= skid_tag;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_data;
    assign bus.out_tag   = main_tag;

endmodule
